// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types, stage indices and helpers for the pipeline control unit
package pipe_ctrl_pkg;

  // Stage positions inside the per-stage stall bus (bit0 is the PC register).
  localparam int STG_ID = 2;
  localparam int STG_EX = 3;

  // Active level of a stall request line.
  localparam logic STOP = 1'b1;

  // Width of the internal flush-hold counter; FLUSH_CYC must fit in it (1..15).
  localparam int FLUSH_CNT_W = 4;

  // Control sequencer states.
  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } ctrl_state_e;

  // Mask with bits [idx:0] set; a stall at a stage also freezes every earlier stage.
  function automatic logic [31:0] low_mask(input int unsigned idx);
    logic [31:0] m;
    if (idx >= 31) begin
      m = '1;
    end else begin
      m = (32'd1 << (idx + 1)) - 32'd1;
    end
    return m;
  endfunction

endpackage

// File: rtl/ctrl_sat_cnt.sv
// rtl/ctrl_sat_cnt.sv - saturating up-counter with enable and synchronous clear
module ctrl_sat_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Clear wins over enable; the count sticks at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - per-stage stall generation, flush sequencing, perf counters and EX watchdog
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int STALL_W   = 6,
  parameter int ID_IDX    = STG_ID,
  parameter int EX_IDX    = STG_EX,
  parameter int PC_W      = 32,
  parameter int FLUSH_CYC = 1,
  parameter int CNT_W     = 32,
  parameter int WDOG_LIM  = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_for_id,
  input  logic               stallreq_for_ex,
  input  logic               excp_req,
  input  logic [PC_W-1:0]    excp_pc,
  output logic [STALL_W-1:0] stall,
  output logic               flush,
  output logic [PC_W-1:0]    new_pc,
  output logic               ex_cancel,
  output logic [CNT_W-1:0]   stall_cycles,
  output logic [CNT_W-1:0]   flush_count,
  output logic               stall_timeout
);

  localparam logic [STALL_W-1:0] EX_MASK = STALL_W'(low_mask(EX_IDX));
  localparam logic [STALL_W-1:0] ID_MASK = STALL_W'(low_mask(ID_IDX));

  localparam int                     WDOG_W     = $clog2(WDOG_LIM + 1);
  localparam logic [WDOG_W-1:0]      WDOG_TOP   = WDOG_W'(WDOG_LIM - 1);
  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYC);

  ctrl_state_e            state_q, state_d;
  logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [PC_W-1:0]        new_pc_q, new_pc_d;
  logic                   flush_q, flush_d;
  logic                   ex_cancel_q, ex_cancel_d;
  logic                   timeout_q, timeout_d;

  logic [STALL_W-1:0]     stall_vec;
  logic                   in_run;
  logic                   take_excp;
  logic                   wdog_en;
  logic                   wdog_clr;
  logic [WDOG_W-1:0]      wdog_cnt;

  assign in_run    = (state_q == ST_RUN);
  assign take_excp = in_run && excp_req;

  // Watchdog only runs on an uninterrupted EX request in RUN; anything else restarts it.
  assign wdog_en  = in_run && stallreq_for_ex;
  assign wdog_clr = !wdog_en;

  // Zero-latency stall vector: EX outranks ID, and nothing stalls while flushing or in reset.
  always_comb begin
    stall_vec = '0;
    if (!rst && in_run) begin
      if (stallreq_for_ex) begin
        stall_vec = EX_MASK;
      end else if (stallreq_for_id == STOP) begin
        stall_vec = ID_MASK;
      end
    end
  end

  // Sequencer next-state: an accepted exception latches the target and arms the hold counter.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    new_pc_d    = new_pc_q;
    flush_d     = flush_q;
    ex_cancel_d = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (excp_req) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = FLUSH_LOAD;
          new_pc_d    = excp_pc;
          flush_d     = 1'b1;
          ex_cancel_d = stallreq_for_ex;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q <= FLUSH_CNT_W'(1)) begin
          state_d     = ST_RUN;
          flush_cnt_d = '0;
          flush_d     = 1'b0;
        end else begin
          flush_cnt_d = flush_cnt_q - FLUSH_CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_RUN;
        flush_d = 1'b0;
      end
    endcase
  end

  // Sticky timeout: set on the WDOG_LIM-th consecutive EX-stall cycle.
  always_comb begin
    timeout_d = timeout_q;
    if (wdog_en && (wdog_cnt >= WDOG_TOP)) begin
      timeout_d = 1'b1;
    end
  end

  // Sequencer state and registered outputs; reset aborts any flush in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= '0;
      new_pc_q    <= '0;
      flush_q     <= 1'b0;
      ex_cancel_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      new_pc_q    <= new_pc_d;
      flush_q     <= flush_d;
      ex_cancel_q <= ex_cancel_d;
      timeout_q   <= timeout_d;
    end
  end

  ctrl_sat_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .en  (|stall_vec),
    .cnt (stall_cycles)
  );

  ctrl_sat_cnt #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .en  (take_excp),
    .cnt (flush_count)
  );

  ctrl_sat_cnt #(.W(WDOG_W)) u_wdog_cnt (
    .clk (clk),
    .rst (rst),
    .clr (wdog_clr),
    .en  (wdog_en),
    .cnt (wdog_cnt)
  );

  assign stall         = stall_vec;
  assign flush         = flush_q;
  assign new_pc        = new_pc_q;
  assign ex_cancel     = ex_cancel_q;
  assign stall_timeout = timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl with a cycle-level reference model
module tb_pipe_ctrl;

  localparam int CNT_MAX = 15;
  localparam int FCYC    = 2;
  localparam int WLIM    = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_for_id;
  logic        stallreq_for_ex;
  logic        excp_req;
  logic [31:0] excp_pc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        ex_cancel;
  logic [3:0]  stall_cycles;
  logic [3:0]  flush_count;
  logic        stall_timeout;

  always #5 clk = ~clk;

  pipe_ctrl #(
    .STALL_W   (6),
    .ID_IDX    (2),
    .EX_IDX    (3),
    .PC_W      (32),
    .FLUSH_CYC (FCYC),
    .CNT_W     (4),
    .WDOG_LIM  (WLIM)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stallreq_for_id (stallreq_for_id),
    .stallreq_for_ex (stallreq_for_ex),
    .excp_req        (excp_req),
    .excp_pc         (excp_pc),
    .stall           (stall),
    .flush           (flush),
    .new_pc          (new_pc),
    .ex_cancel       (ex_cancel),
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count),
    .stall_timeout   (stall_timeout)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model state
  int          m_left   = 0;
  logic [31:0] m_pc     = '0;
  bit          m_cancel = 1'b0;
  int          m_scyc   = 0;
  int          m_fcnt   = 0;
  int          m_wd     = 0;
  bit          m_to     = 1'b0;

  function automatic logic [5:0] exp_stall();
    if (rst || m_left > 0) return 6'b000000;
    if (stallreq_for_ex) return 6'b001111;
    if (stallreq_for_id) return 6'b000111;
    return 6'b000000;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic i, input logic e, input logic x,
                       input logic [31:0] pc);
    rst             = r;
    stallreq_for_id = i;
    stallreq_for_ex = e;
    excp_req        = x;
    excp_pc         = pc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model update on every rising edge from the inputs of the cycle just ending
  initial forever begin
    logic [5:0] s;
    @(posedge clk);
    s = exp_stall();
    if (rst) begin
      m_left = 0; m_pc = '0; m_cancel = 1'b0;
      m_scyc = 0; m_fcnt = 0; m_wd = 0; m_to = 1'b0;
    end else begin
      if (s != 6'b0 && m_scyc < CNT_MAX) m_scyc++;
      if (m_left > 0) begin
        m_left--;
        m_cancel = 1'b0;
        m_wd = 0;
      end else begin
        if (stallreq_for_ex) begin
          m_wd++;
          if (m_wd >= WLIM) m_to = 1'b1;
        end else begin
          m_wd = 0;
        end
        if (excp_req) begin
          m_left   = FCYC;
          m_pc     = excp_pc;
          m_cancel = stallreq_for_ex;
          if (m_fcnt < CNT_MAX) m_fcnt++;
        end else begin
          m_cancel = 1'b0;
        end
      end
    end
  end

  // Every-cycle comparison mid-cycle
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("stall", 32'(stall), 32'(exp_stall()));
      check("flush", 32'(flush), 32'(m_left > 0));
      check("ex_cancel", 32'(ex_cancel), 32'(m_cancel));
      check("stall_cycles", 32'(stall_cycles), 32'(m_scyc));
      check("flush_count", 32'(flush_count), 32'(m_fcnt));
      check("stall_timeout", 32'(stall_timeout), 32'(m_to));
      if (m_left > 0) check("new_pc", new_pc, m_pc);
    end
  end

  initial begin
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_1234);
    @(posedge clk);
    #1 chk_en = 1'b1;
    #2;
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_flush", 32'(flush), 32'h0);
    check("rst_new_pc", new_pc, 32'h0);
    check("rst_stall_cycles", 32'(stall_cycles), 32'h0);
    check("rst_flush_count", 32'(flush_count), 32'h0);
    tick();
    tick();

    // ID stall two cycles, then EX on top of ID
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    #2 check("id_stall_1", 32'(stall), 32'h07);
    tick();
    #2 check("id_stall_2", 32'(stall), 32'h07);
    check("stall_cycles_1", 32'(stall_cycles), 32'h1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #2 check("stall_cycles_2", 32'(stall_cycles), 32'h2);
    tick();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    #2 check("ex_over_id", 32'(stall), 32'h0F);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();

    // Exception with repeats during the flush window
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hBFC0_0380);
    tick();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF);
    #2;
    check("f1_flush", 32'(flush), 32'h1);
    check("f1_new_pc", new_pc, 32'hBFC0_0380);
    check("f1_stall", 32'(stall), 32'h0);
    check("f1_flush_count", 32'(flush_count), 32'h1);
    check("f1_ex_cancel", 32'(ex_cancel), 32'h0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    #2;
    check("f2_flush", 32'(flush), 32'h1);
    check("f2_new_pc", new_pc, 32'hBFC0_0380);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #2;
    check("run_flush", 32'(flush), 32'h0);
    check("run_flush_count", 32'(flush_count), 32'h1);
    tick();

    // Exception while EX busy cancels the EX op and clears the watchdog
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h8000_0180);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #2;
    check("cancel_pulse", 32'(ex_cancel), 32'h1);
    check("cancel_new_pc", new_pc, 32'h8000_0180);
    tick();
    #2 check("cancel_off", 32'(ex_cancel), 32'h0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    repeat (7) tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #2 check("wdog_cleared", 32'(stall_timeout), 32'h0);
    tick();

    // Watchdog trips after exactly WLIM cycles and is sticky
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    repeat (7) tick();
    #2 check("wdog_7", 32'(stall_timeout), 32'h0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #2 check("wdog_8", 32'(stall_timeout), 32'h1);
    repeat (3) tick();
    #2 check("wdog_sticky", 32'(stall_timeout), 32'h1);

    // Counter saturation from a clean reset
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    repeat (14) tick();
    #2 check("scyc_14", 32'(stall_cycles), 32'd14);
    repeat (6) tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #2;
    check("scyc_sat", 32'(stall_cycles), 32'd15);
    check("wdog_rst", 32'(stall_timeout), 32'h0);
    tick();

    // Reset in the middle of a flush
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_00A0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    #2 check("mid_flush", 32'(flush), 32'h1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #2;
    check("abort_flush", 32'(flush), 32'h0);
    check("abort_fcount", 32'(flush_count), 32'h0);
    tick();

    // Back-to-back: a request held through the flush is taken in the first RUN cycle
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0100);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0200);
    tick();
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0300);
    #2 check("b2b_run", 32'(flush), 32'h0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #2;
    check("b2b_flush", 32'(flush), 32'h1);
    check("b2b_new_pc", new_pc, 32'h0000_0300);
    check("b2b_fcount", 32'(flush_count), 32'h2);
    repeat (3) tick();

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
